mac_mgnt_dispatch: RTL and testbench
====================================

Name: mac_mgnt_dispatch

Overview:
- Single-clock management-request dispatcher between the system-side byte-serial register bus and NUM_PORTS per-port MAC control blocks.
- Routes each request (valid/wr/addr, then data or response bytes) to the port chosen by a port-select field. Returns that port's response bytes upstream.
- Adds behaviour the per-port interface lacks: bad-port rejection, a per-transaction watchdog timeout and an error flag, so a dead or unlinked port never hangs the system bus.

Parameters:
- NUM_PORTS, 4: number of downstream MAC control ports (1..16).
- PORT_W, 2: width of the port-select field; must satisfy 2^PORT_W >= NUM_PORTS.
- XFER_BYTES, 2: data bytes per write, and response bytes per read (1..8).
- TIMEOUT, 255: idle cycles allowed between progress events before abort (1..65535).

Ports:
- clk  in  1  system clock.
- rst_sys  in  1  synchronous, active-high reset.
- sys_req_valid  in  1  request pending; held high until sys_req_ack.
- sys_req_wr  in  1  1 = write, 0 = read; stable while sys_req_valid is high.
- sys_req_port  in  PORT_W  target port index.
- sys_req_addr  in  8  register address.
- sys_req_ack  out  1  one-cycle request accept pulse.
- sys_req_data  in  8  write data byte.
- sys_req_data_valid  in  1  write byte strobe; legal only after sys_req_ack.
- sys_resp_data  out  8  read response byte.
- sys_resp_data_valid  out  1  response byte strobe.
- sys_resp_err  out  1  one-cycle pulse: bad port or timeout.
- busy  out  1  high whenever the FSM is not in IDLE.
- port_req_valid  out  NUM_PORTS  one-hot request valid.
- port_req_wr  out  1  shared write flag.
- port_req_addr  out  8  shared address.
- port_req_ack  in  NUM_PORTS  per-port accept pulse.
- port_req_data  out  8  shared write byte.
- port_req_data_valid  out  NUM_PORTS  one-hot write strobe.
- port_resp_data  in  8*NUM_PORTS  per-port response byte; port n occupies bits [8n+7:8n].
- port_resp_data_valid  in  NUM_PORTS  per-port response strobe.

Behaviour:
- Reset: all outputs are registered and reset to 0. FSM goes to IDLE. Byte counter and watchdog clear. A reset mid-transaction drops port_req_valid the next cycle; no error is reported.
- States:
  - IDLE: when sys_req_valid is high, latch wr/port/addr and clear the watchdog.
    - port < NUM_PORTS: go to REQ.
    - Otherwise: go to ERR.
  - REQ: port_req_valid[sel] = 1.
    - On port_req_ack[sel]: drop valid, pulse sys_req_ack the next cycle, go to WDATA (wr=1) or RDATA (wr=0).
    - Acks from non-selected ports are ignored.
  - WDATA: each sys_req_data_valid forwards the byte to port_req_data with port_req_data_valid[sel], 1-cycle latency, and increments the counter. Once XFER_BYTES bytes are forwarded, go to IDLE.
  - RDATA: each port_resp_data_valid[sel] forwards the byte to sys_resp_data with sys_resp_data_valid, 1-cycle latency. Once XFER_BYTES bytes are forwarded, go to IDLE. Response strobes from other ports are ignored.
  - ERR: pulse sys_req_ack, but only if the request was not yet acked.
    - Read: emit the remaining (XFER_BYTES - count) bytes of 8'hFF with sys_resp_data_valid, one per cycle. Pulse sys_resp_err together with the last byte.
    - Write: pulse sys_resp_err once.
    - Then go to IDLE.
- Watchdog (16-bit):
  - Clears on state entry and on every ack or byte event.
  - Otherwise increments in REQ, WDATA and RDATA.
  - Reaching TIMEOUT goes to ERR and drops port_req_valid.
  - If the watchdog reaches TIMEOUT in the same cycle as an ack or byte event, the event wins and the watchdog clears.
- sys_req_valid is ignored outside IDLE. The next request is accepted one cycle after returning to IDLE at the earliest.
- Extra sys_req_data_valid strobes after XFER_BYTES, or while IDLE, are dropped.
- Minimum read latency: request to sys_req_ack is 3 cycles if the port acks in the cycle after port_req_valid rises.

Test Plan:
- Write, port 2, addr 0x10, bytes 0xAB 0xCD: port_req_valid = 4'b0100 until ack. sys_req_ack follows one cycle after port ack. Port 2 receives 0xAB, 0xCD with data_valid. sys_resp_err never pulses.
- Read, port 1, addr 0x05: port 1 returns 0x12, 0x34. Upstream gets 0x12, 0x34, each one cycle after its port strobe. Port 3 strobing 0x99 at the same time is ignored.
- Read of port 5 with NUM_PORTS=4, PORT_W=3: no port_req_valid bit rises. sys_req_ack pulses. Upstream gets 0xFF, 0xFF; sys_resp_err pulses with the second byte.
- Read, port 0, ack given but only 0x77 returned (TIMEOUT=8): after 0x77, 8 idle cycles then 0xFF with sys_resp_err. busy = 0 the cycle after.
- Write to port 3 whose ack never comes: port_req_valid[3] drops after TIMEOUT cycles. sys_req_ack and sys_resp_err both pulse. A new read to port 0 then completes normally.
- Assert rst_sys in RDATA after one byte: all outputs are 0 the next cycle. A following read to port 1 returns both bytes and no error.

Source files
------------

// File: rtl/mac_mgnt_dispatch.sv
// Management-request dispatcher: routes one byte-serial register request from
// the system bus to one of NUM_PORTS MAC control ports. It returns read bytes
// upstream. Bad port indices and stalled ports are turned into an error
// completion, so the system bus never hangs.
//
// Ports:
//   clk, rst_sys                      clock, synchronous active-high reset
//   sys_req_*                         upstream request, ack and write bytes
//   sys_resp_data/_valid/_err         upstream read bytes and error pulse
//   busy                              transaction in progress
//   port_req_valid/_data_valid        one-hot per-port request / write strobe
//   port_req_wr/_addr/_data           shared request fields
//   port_req_ack, port_resp_data/_valid  per-port handshake and read bytes
module mac_mgnt_dispatch #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned PORT_W     = 2,
    parameter int unsigned XFER_BYTES = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                   clk,
    input  logic                   rst_sys,
    input  logic                   sys_req_valid,
    input  logic                   sys_req_wr,
    input  logic [PORT_W-1:0]      sys_req_port,
    input  logic [7:0]             sys_req_addr,
    output logic                   sys_req_ack,
    input  logic [7:0]             sys_req_data,
    input  logic                   sys_req_data_valid,
    output logic [7:0]             sys_resp_data,
    output logic                   sys_resp_data_valid,
    output logic                   sys_resp_err,
    output logic                   busy,
    output logic [NUM_PORTS-1:0]   port_req_valid,
    output logic                   port_req_wr,
    output logic [7:0]             port_req_addr,
    input  logic [NUM_PORTS-1:0]   port_req_ack,
    output logic [7:0]             port_req_data,
    output logic [NUM_PORTS-1:0]   port_req_data_valid,
    input  logic [8*NUM_PORTS-1:0] port_resp_data,
    input  logic [NUM_PORTS-1:0]   port_resp_data_valid
);

    localparam int unsigned CNT_W = $clog2(XFER_BYTES + 1);
    localparam int unsigned WD_W  = 16;

    typedef enum logic [2:0] {IDLE, REQ, WDATA, RDATA, ERR} state_t;

    state_t              state, state_nxt;
    logic [PORT_W-1:0]   sel, sel_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [WD_W-1:0]     wd, wd_nxt;
    logic                acked, acked_nxt;

    logic                sys_req_ack_nxt;
    logic [7:0]          sys_resp_data_nxt;
    logic                sys_resp_data_valid_nxt;
    logic                sys_resp_err_nxt;
    logic                busy_nxt;
    logic [NUM_PORTS-1:0] port_req_valid_nxt;
    logic                port_req_wr_nxt;
    logic [7:0]          port_req_addr_nxt;
    logic [7:0]          port_req_data_nxt;
    logic [NUM_PORTS-1:0] port_req_data_valid_nxt;

    logic [NUM_PORTS-1:0] sel_onehot;
    logic                ack_hit, resp_hit, last_byte, wd_expired, port_ok;

    // Decode of the latched port; one-hot masks avoid out-of-range bit selects
    // when PORT_W can address more ports than exist.
    always_comb begin
        sel_onehot = NUM_PORTS'(1) << sel;
        ack_hit    = |(port_req_ack & sel_onehot);
        resp_hit   = |(port_resp_data_valid & sel_onehot);
        last_byte  = (cnt == CNT_W'(XFER_BYTES - 1));
        wd_expired = (wd == WD_W'(TIMEOUT - 1));
        port_ok    = (32'(sys_req_port) < NUM_PORTS);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt               = state;
        sel_nxt                 = sel;
        cnt_nxt                 = cnt;
        wd_nxt                  = wd;
        acked_nxt               = acked;
        sys_req_ack_nxt         = 1'b0;
        sys_resp_data_nxt       = sys_resp_data;
        sys_resp_data_valid_nxt = 1'b0;
        sys_resp_err_nxt        = 1'b0;
        port_req_wr_nxt         = port_req_wr;
        port_req_addr_nxt       = port_req_addr;
        port_req_data_nxt       = port_req_data;
        port_req_data_valid_nxt = '0;

        case (state)
            IDLE: begin
                if (sys_req_valid) begin
                    port_req_wr_nxt   = sys_req_wr;
                    port_req_addr_nxt = sys_req_addr;
                    sel_nxt           = sys_req_port;
                    cnt_nxt           = '0;
                    wd_nxt            = '0;
                    acked_nxt         = 1'b0;
                    state_nxt         = port_ok ? REQ : ERR;
                end
            end
            REQ: begin
                if (ack_hit) begin
                    sys_req_ack_nxt = 1'b1;
                    acked_nxt       = 1'b1;
                    wd_nxt          = '0;
                    state_nxt       = port_req_wr ? WDATA : RDATA;
                end else if (wd_expired) begin
                    wd_nxt    = '0;
                    state_nxt = ERR;
                end else begin
                    wd_nxt = wd + WD_W'(1);
                end
            end
            WDATA: begin
                if (sys_req_data_valid) begin
                    port_req_data_nxt       = sys_req_data;
                    port_req_data_valid_nxt = sel_onehot;
                    cnt_nxt                 = cnt + CNT_W'(1);
                    wd_nxt                  = '0;
                    if (last_byte) state_nxt = IDLE;
                end else if (wd_expired) begin
                    wd_nxt    = '0;
                    state_nxt = ERR;
                end else begin
                    wd_nxt = wd + WD_W'(1);
                end
            end
            RDATA: begin
                if (resp_hit) begin
                    sys_resp_data_nxt       = 8'(port_resp_data >> {sel, 3'b000});
                    sys_resp_data_valid_nxt = 1'b1;
                    cnt_nxt                 = cnt + CNT_W'(1);
                    wd_nxt                  = '0;
                    if (last_byte) state_nxt = IDLE;
                end else if (wd_expired) begin
                    wd_nxt    = '0;
                    state_nxt = ERR;
                end else begin
                    wd_nxt = wd + WD_W'(1);
                end
            end
            ERR: begin
                // Complete the handshake once, then pad a read with 0xFF bytes.
                sys_req_ack_nxt = ~acked;
                acked_nxt       = 1'b1;
                if (!port_req_wr) begin
                    sys_resp_data_nxt       = 8'hFF;
                    sys_resp_data_valid_nxt = 1'b1;
                    cnt_nxt                 = cnt + CNT_W'(1);
                    if (last_byte) begin
                        sys_resp_err_nxt = 1'b1;
                        state_nxt        = IDLE;
                    end
                end else begin
                    sys_resp_err_nxt = 1'b1;
                    state_nxt        = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        port_req_valid_nxt = (state_nxt == REQ) ? (NUM_PORTS'(1) << sel_nxt) : '0;
        busy_nxt           = (state_nxt != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst_sys) begin
            state               <= IDLE;
            sel                 <= '0;
            cnt                 <= '0;
            wd                  <= '0;
            acked               <= 1'b0;
            sys_req_ack         <= 1'b0;
            sys_resp_data       <= '0;
            sys_resp_data_valid <= 1'b0;
            sys_resp_err        <= 1'b0;
            busy                <= 1'b0;
            port_req_valid      <= '0;
            port_req_wr         <= 1'b0;
            port_req_addr       <= '0;
            port_req_data       <= '0;
            port_req_data_valid <= '0;
        end else begin
            state               <= state_nxt;
            sel                 <= sel_nxt;
            cnt                 <= cnt_nxt;
            wd                  <= wd_nxt;
            acked               <= acked_nxt;
            sys_req_ack         <= sys_req_ack_nxt;
            sys_resp_data       <= sys_resp_data_nxt;
            sys_resp_data_valid <= sys_resp_data_valid_nxt;
            sys_resp_err        <= sys_resp_err_nxt;
            busy                <= busy_nxt;
            port_req_valid      <= port_req_valid_nxt;
            port_req_wr         <= port_req_wr_nxt;
            port_req_addr       <= port_req_addr_nxt;
            port_req_data       <= port_req_data_nxt;
            port_req_data_valid <= port_req_data_valid_nxt;
        end
    end

endmodule

// File: tb/tb_mac_mgnt_dispatch.sv
// Directed bench for mac_mgnt_dispatch (NUM_PORTS=4, PORT_W=3, XFER_BYTES=2,
// TIMEOUT=8). One vector per clock: inputs are held for the cycle and the row's
// expected outputs are what the registers show just after the closing edge.
module tb_mac_mgnt_dispatch;

    localparam int unsigned NP = 4;

    logic        clk = 1'b0;
    logic        rst_sys;
    logic        sys_req_valid, sys_req_wr;
    logic [2:0]  sys_req_port;
    logic [7:0]  sys_req_addr, sys_req_data;
    logic        sys_req_data_valid;
    logic        sys_req_ack;
    logic [7:0]  sys_resp_data;
    logic        sys_resp_data_valid, sys_resp_err, busy;
    logic [3:0]  port_req_valid, port_req_data_valid, port_req_ack, port_resp_data_valid;
    logic        port_req_wr;
    logic [7:0]  port_req_addr, port_req_data;
    logic [31:0] port_resp_data;

    int n_tests = 0;
    int n_fail  = 0;

    mac_mgnt_dispatch #(.NUM_PORTS(NP), .PORT_W(3), .XFER_BYTES(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst_sys(rst_sys),
        .sys_req_valid(sys_req_valid), .sys_req_wr(sys_req_wr),
        .sys_req_port(sys_req_port), .sys_req_addr(sys_req_addr),
        .sys_req_ack(sys_req_ack), .sys_req_data(sys_req_data),
        .sys_req_data_valid(sys_req_data_valid), .sys_resp_data(sys_resp_data),
        .sys_resp_data_valid(sys_resp_data_valid), .sys_resp_err(sys_resp_err),
        .busy(busy), .port_req_valid(port_req_valid), .port_req_wr(port_req_wr),
        .port_req_addr(port_req_addr), .port_req_ack(port_req_ack),
        .port_req_data(port_req_data), .port_req_data_valid(port_req_data_valid),
        .port_resp_data(port_resp_data), .port_resp_data_valid(port_resp_data_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        wr;
        logic [2:0]  port;
        logic [7:0]  addr;
        logic        wdv;
        logic [7:0]  wdata;
        logic [3:0]  pack;
        logic [3:0]  rv;
        logic [31:0] rd;
        logic [36:0] exp;
    } vec_t;

    // Output bundle: ack, rdata, rdv, err, busy, prv, pwr, paddr, pdata, pdv.
    function automatic logic [36:0] o(input logic ack, input logic [7:0] rdata,
                                      input logic rdv, input logic err, input logic bsy,
                                      input logic [3:0] prv, input logic pwr,
                                      input logic [7:0] paddr, input logic [7:0] pdata,
                                      input logic [3:0] pdv);
        return {ack, rdata, rdv, err, bsy, prv, pwr, paddr, pdata, pdv};
    endfunction

    function automatic logic [36:0] outs();
        return {sys_req_ack, sys_resp_data, sys_resp_data_valid, sys_resp_err, busy,
                port_req_valid, port_req_wr, port_req_addr, port_req_data, port_req_data_valid};
    endfunction

    function automatic vec_t v(input logic valid, input logic wr, input logic [2:0] port,
                               input logic [7:0] addr, input logic wdv, input logic [7:0] wdata,
                               input logic [3:0] pack, input logic [3:0] rv,
                               input logic [31:0] rd, input logic [36:0] exp);
        vec_t r;
        r.valid = valid; r.wr = wr; r.port = port; r.addr = addr; r.wdv = wdv;
        r.wdata = wdata; r.pack = pack; r.rv = rv; r.rd = rd; r.exp = exp;
        return r;
    endfunction

    task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sys_req_valid = 1'b0; sys_req_wr = 1'b0; sys_req_port = '0; sys_req_addr = '0;
        sys_req_data = '0; sys_req_data_valid = 1'b0;
        port_req_ack = '0; port_resp_data = '0; port_resp_data_valid = '0;
    endtask

    task automatic req(input logic wr, input logic [2:0] port, input logic [7:0] addr);
        sys_req_valid = 1'b1; sys_req_wr = wr; sys_req_port = port; sys_req_addr = addr;
    endtask

    // Read strobe from one port.
    task automatic pbyte(input int p, input logic [7:0] b);
        port_resp_data = 32'(b) << (8 * p);
        port_resp_data_valid = 4'(1) << p;
    endtask

    // Clean read of two bytes from port p, starting from IDLE.
    task automatic good_read(input string tag, input int p, input logic [7:0] b0, input logic [7:0] b1);
        req(1'b0, 3'(p), 8'h55);
        tick();
        chk({tag, "_valid"}, 37'(port_req_valid), 37'(4'(1) << p));
        port_req_ack = 4'(1) << p;
        tick();
        chk({tag, "_ack"}, 37'(sys_req_ack), 37'(1));
        idle_inputs();
        pbyte(p, b0);
        tick();
        chk({tag, "_b0"}, 37'({sys_resp_data_valid, sys_resp_data, sys_resp_err}), 37'({1'b1, b0, 1'b0}));
        pbyte(p, b1);
        tick();
        chk({tag, "_b1"}, 37'({sys_resp_data_valid, sys_resp_data, sys_resp_err, busy}),
            37'({1'b1, b1, 1'b0, 1'b0}));
        idle_inputs();
    endtask

    vec_t vecs[19];

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Write p2 @10 (AB, CD) with a stray p3 ack and an extra strobe in IDLE.
        vecs[0]  = v(1,1,2,8'h10, 0,8'h00, 4'b0000,4'b0000,32'h0, o(0,8'h00,0,0,1,4'b0100,1,8'h10,8'h00,4'b0000));
        vecs[1]  = v(1,1,2,8'h10, 0,8'h00, 4'b0000,4'b0000,32'h0, o(0,8'h00,0,0,1,4'b0100,1,8'h10,8'h00,4'b0000));
        vecs[2]  = v(1,1,2,8'h10, 0,8'h00, 4'b1000,4'b0000,32'h0, o(0,8'h00,0,0,1,4'b0100,1,8'h10,8'h00,4'b0000));
        vecs[3]  = v(1,1,2,8'h10, 0,8'h00, 4'b0100,4'b0000,32'h0, o(1,8'h00,0,0,1,4'b0000,1,8'h10,8'h00,4'b0000));
        vecs[4]  = v(1,1,2,8'h10, 0,8'h00, 4'b0000,4'b0000,32'h0, o(0,8'h00,0,0,1,4'b0000,1,8'h10,8'h00,4'b0000));
        vecs[5]  = v(0,0,0,8'h00, 1,8'hAB, 4'b0000,4'b0000,32'h0, o(0,8'h00,0,0,1,4'b0000,1,8'h10,8'hAB,4'b0100));
        vecs[6]  = v(0,0,0,8'h00, 0,8'h00, 4'b0000,4'b0000,32'h0, o(0,8'h00,0,0,1,4'b0000,1,8'h10,8'hAB,4'b0000));
        vecs[7]  = v(0,0,0,8'h00, 1,8'hCD, 4'b0000,4'b0000,32'h0, o(0,8'h00,0,0,0,4'b0000,1,8'h10,8'hCD,4'b0100));
        vecs[8]  = v(0,0,0,8'h00, 1,8'hEE, 4'b0000,4'b0000,32'h0, o(0,8'h00,0,0,0,4'b0000,1,8'h10,8'hCD,4'b0000));
        // Read p1 @05 returning 12, 34 while p3 strobes 99.
        vecs[9]  = v(1,0,1,8'h05, 0,8'h00, 4'b0000,4'b0000,32'h0,         o(0,8'h00,0,0,1,4'b0010,0,8'h05,8'hCD,4'b0000));
        vecs[10] = v(1,0,1,8'h05, 0,8'h00, 4'b0010,4'b0000,32'h0,         o(1,8'h00,0,0,1,4'b0000,0,8'h05,8'hCD,4'b0000));
        vecs[11] = v(0,0,0,8'h00, 0,8'h00, 4'b0000,4'b1010,32'h9900_1200, o(0,8'h12,1,0,1,4'b0000,0,8'h05,8'hCD,4'b0000));
        vecs[12] = v(0,0,0,8'h00, 0,8'h00, 4'b0000,4'b1000,32'h9900_0000, o(0,8'h12,0,0,1,4'b0000,0,8'h05,8'hCD,4'b0000));
        vecs[13] = v(0,0,0,8'h00, 0,8'h00, 4'b0000,4'b1010,32'h9900_3400, o(0,8'h34,1,0,0,4'b0000,0,8'h05,8'hCD,4'b0000));
        vecs[14] = v(0,0,0,8'h00, 0,8'h00, 4'b0000,4'b0000,32'h0,         o(0,8'h34,0,0,0,4'b0000,0,8'h05,8'hCD,4'b0000));
        // Read of nonexistent port 5: ack, FF, FF + err, no port valid.
        vecs[15] = v(1,0,5,8'h22, 0,8'h00, 4'b0000,4'b0000,32'h0, o(0,8'h34,0,0,1,4'b0000,0,8'h22,8'hCD,4'b0000));
        vecs[16] = v(1,0,5,8'h22, 0,8'h00, 4'b0000,4'b0000,32'h0, o(1,8'hFF,1,0,1,4'b0000,0,8'h22,8'hCD,4'b0000));
        vecs[17] = v(0,0,0,8'h00, 0,8'h00, 4'b0000,4'b0000,32'h0, o(0,8'hFF,1,1,0,4'b0000,0,8'h22,8'hCD,4'b0000));
        vecs[18] = v(0,0,0,8'h00, 0,8'h00, 4'b0000,4'b0000,32'h0, o(0,8'hFF,0,0,0,4'b0000,0,8'h22,8'hCD,4'b0000));

        idle_inputs();
        rst_sys = 1'b1;
        tick();
        tick();
        chk("reset_state", outs(), 37'(0));
        rst_sys = 1'b0;

        for (int i = 0; i < 19; i++) begin
            sys_req_valid = vecs[i].valid; sys_req_wr = vecs[i].wr;
            sys_req_port = vecs[i].port; sys_req_addr = vecs[i].addr;
            sys_req_data_valid = vecs[i].wdv; sys_req_data = vecs[i].wdata;
            port_req_ack = vecs[i].pack; port_resp_data_valid = vecs[i].rv;
            port_resp_data = vecs[i].rd;
            tick();
            chk($sformatf("vec[%0d]", i), outs(), vecs[i].exp);
        end
        idle_inputs();
        tick();

        // Read p0: one byte then silence; pad byte + err after 8 idle cycles.
        req(1'b0, 3'd0, 8'h40);
        tick();
        chk("to_rd_valid", 37'(port_req_valid), 37'(4'b0001));
        port_req_ack = 4'b0001;
        tick();
        chk("to_rd_ack", 37'(sys_req_ack), 37'(1));
        idle_inputs();
        pbyte(0, 8'h77);
        tick();
        chk("to_rd_b0", 37'({sys_resp_data_valid, sys_resp_data}), 37'({1'b1, 8'h77}));
        idle_inputs();
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("to_rd_wait%0d", i), 37'({sys_resp_data_valid, sys_resp_err, busy}), 37'(3'b001));
        end
        tick();
        chk("to_rd_pad", 37'({sys_resp_data_valid, sys_resp_data, sys_resp_err, sys_req_ack}),
            37'({1'b1, 8'hFF, 1'b1, 1'b0}));
        tick();
        chk("to_rd_after", 37'({busy, sys_resp_err, sys_resp_data_valid}), 37'(0));

        // Write p3 with no ack: valid held 8 cycles, then ack + err together.
        req(1'b1, 3'd3, 8'h33);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("to_wr_valid%0d", i), 37'({port_req_valid, sys_req_ack, sys_resp_err}),
                37'({4'b1000, 1'b0, 1'b0}));
        end
        tick();
        chk("to_wr_drop", 37'({port_req_valid, sys_req_ack, sys_resp_err}), 37'(0));
        tick();
        chk("to_wr_err", 37'({sys_req_ack, sys_resp_err, sys_resp_data_valid, busy}), 37'(4'b1100));
        idle_inputs();
        tick();
        good_read("after_to", 0, 8'h5A, 8'hA5);

        // Reset in RDATA after one byte, then a clean read of p1.
        tick();
        req(1'b0, 3'd2, 8'h60);
        tick();
        port_req_ack = 4'b0100;
        tick();
        idle_inputs();
        pbyte(2, 8'h11);
        tick();
        chk("rst_mid_b0", 37'({sys_resp_data_valid, sys_resp_data}), 37'({1'b1, 8'h11}));
        idle_inputs();
        rst_sys = 1'b1;
        tick();
        chk("rst_mid_outs", outs(), 37'(0));
        rst_sys = 1'b0;
        tick();
        chk("rst_mid_idle", outs(), 37'(0));
        good_read("after_rst", 1, 8'h21, 8'h43);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
